// File: rtl/mm_pkg.sv
// Shared types and widths for the multimeter RMS path and its square-root unit.
package mm_pkg;

  localparam int ACC_W  = 40;
  localparam int RES_W  = 16;
  localparam int MAG_W  = 16;
  localparam int PROD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    SQUARE,
    ACCUM,
    REQ,
    WAIT,
    DONE
  } rms_state_t;

  // Two's-complement magnitude; -32768 maps to 0x8000, which still fits unsigned.
  function automatic logic [MAG_W-1:0] abs16(input logic [MAG_W-1:0] v);
    return v[MAG_W-1] ? (~v + MAG_W'(1)) : v;
  endfunction

endpackage

// File: rtl/shift_add_sq16.sv
// Iterative unsigned 16x16 squarer: one shift-add step per cycle, 16 cycles per operand.
module shift_add_sq16
  import mm_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [MAG_W-1:0]  i_mag,
  output logic              o_done,
  output logic [PROD_W-1:0] o_prod
);

  logic [MAG_W-1:0]  r_mag;
  logic [PROD_W-1:0] r_prod;
  logic [3:0]        r_k;
  logic              r_run;
  logic [PROD_W-1:0] w_addend;

  assign w_addend = r_mag[r_k] ? (PROD_W'(r_mag) << r_k) : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mag  <= '0;
      r_prod <= '0;
      r_k    <= '0;
      r_run  <= 1'b0;
    end else if (i_start) begin
      r_mag  <= i_mag;
      r_prod <= '0;
      r_k    <= '0;
      r_run  <= 1'b1;
    end else if (r_run) begin
      r_prod <= r_prod + w_addend;
      r_k    <= r_k + 4'd1;
      if (r_k == 4'd15) r_run <= 1'b0;
    end
  end

  // o_done marks the final iteration; o_prod is complete from the next cycle on.
  assign o_done = r_run && (r_k == 4'd15);
  assign o_prod = r_prod;

endmodule

// File: rtl/rms_sqrt_requester.sv
// Squares and averages a window of ADC samples, then requests the square root
// of the mean square and publishes it as the RMS value.
//
// state  | meaning
// IDLE   | ready for a sample
// SQUARE | squarer running on the accepted magnitude
// ACCUM  | add square to window sum, count sample
// REQ    | start pulse to the sqrt unit with the mean square
// WAIT   | waiting for the sqrt result or timeout
// DONE   | rms_valid_o pulse
module rms_sqrt_requester
  import mm_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int LOG2_N   = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sample_valid_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic                sample_ready_o,
  output logic                sqrt_start_o,
  output logic [ACC_W-1:0]    sqrt_a_o,
  input  logic                sqrt_valid_i,
  input  logic [RES_W-1:0]    sqrt_result_i,
  output logic                rms_valid_o,
  output logic [RES_W-1:0]    rms_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  rms_state_t        r_state;
  rms_state_t        w_next;
  logic [ACC_W-1:0]  r_acc;
  logic [LOG2_N-1:0] r_cnt;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_start;
  logic [ACC_W-1:0]  r_a;
  logic [RES_W-1:0]  r_rms;
  logic              r_rms_valid;
  logic              r_busy;
  logic              r_err;

  logic              w_accept;
  logic              w_cnt_last;
  logic              w_tmo_last;
  logic              w_sq_done;
  logic [PROD_W-1:0] w_prod;
  logic [ACC_W-1:0]  w_acc_sum;

  shift_add_sq16 u_sq (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_start (w_accept),
    .i_mag   (abs16(sample_i)),
    .o_done  (w_sq_done),
    .o_prod  (w_prod)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (sample_valid_i) w_next = SQUARE;
      SQUARE:  if (w_sq_done) w_next = ACCUM;
      ACCUM:   w_next = w_cnt_last ? REQ : IDLE;
      REQ:     w_next = WAIT;
      WAIT: begin
        if (sqrt_valid_i)    w_next = DONE;
        else if (w_tmo_last) w_next = IDLE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    sample_ready_o = (r_state == IDLE);
    w_accept       = (r_state == IDLE) && sample_valid_i;
    w_cnt_last     = &r_cnt;
    w_tmo_last     = (r_tmo == TMO_W'(TIMEOUT - 1));
    w_acc_sum      = r_acc + ACC_W'(w_prod);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_start     <= 1'b0;
      r_a         <= '0;
      r_rms       <= '0;
      r_rms_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_start     <= (w_next == REQ);
      r_rms_valid <= (w_next == DONE);
      r_busy      <= (w_next != IDLE);
      case (r_state)
        IDLE: if (sample_valid_i) r_err <= 1'b0;
        ACCUM: begin
          r_acc <= w_acc_sum;
          r_cnt <= r_cnt + LOG2_N'(1);
          // Operand is formed here so it is already stable in the start cycle.
          if (w_cnt_last) r_a <= w_acc_sum >> LOG2_N;
        end
        REQ: begin
          r_acc <= '0;
          r_cnt <= '0;
          r_tmo <= '0;
        end
        WAIT: begin
          if (sqrt_valid_i)    r_rms <= sqrt_result_i;
          else if (w_tmo_last) r_err <= 1'b1;
          else                 r_tmo <= r_tmo + TMO_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign sqrt_start_o = r_start;
  assign sqrt_a_o     = r_a;
  assign rms_valid_o  = r_rms_valid;
  assign rms_o        = r_rms;
  assign busy_o       = r_busy;
  assign err_o        = r_err;

endmodule

// File: tb/tb_rms_sqrt_requester.sv
// Scoreboard bench for rms_sqrt_requester: a 4-sample instance for most scenarios
// and a 256-sample instance for the full-scale window.
module tb_rms_sqrt_requester;

  logic        clk = 1'b0;
  logic        rst;

  logic        sample_valid_i;
  logic [15:0] sample_i;
  logic        sample_ready_o;
  logic        sqrt_start_o;
  logic [39:0] sqrt_a_o;
  logic        sqrt_valid_i;
  logic [15:0] sqrt_result_i;
  logic        rms_valid_o;
  logic [15:0] rms_o;
  logic        busy_o;
  logic        err_o;

  logic        b_sample_valid;
  logic [15:0] b_sample;
  logic        b_ready;
  logic        b_start;
  logic [39:0] b_a;
  logic        b_sqrt_valid;
  logic [15:0] b_sqrt_result;
  logic        b_rms_valid;
  logic [15:0] b_rms;
  logic        b_busy;
  logic        b_err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int s_cyc = 0;
  int n_start = 0;
  int n_rms = 0;
  int sq_lat = 20;
  logic [63:0] m_a;
  logic [63:0] q_a[$];
  logic [63:0] q_rms[$];

  rms_sqrt_requester #(.SAMPLE_W(16), .LOG2_N(2), .TIMEOUT(64)) u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .sample_valid_i (sample_valid_i),
    .sample_i       (sample_i),
    .sample_ready_o (sample_ready_o),
    .sqrt_start_o   (sqrt_start_o),
    .sqrt_a_o       (sqrt_a_o),
    .sqrt_valid_i   (sqrt_valid_i),
    .sqrt_result_i  (sqrt_result_i),
    .rms_valid_o    (rms_valid_o),
    .rms_o          (rms_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  rms_sqrt_requester #(.SAMPLE_W(16), .LOG2_N(8), .TIMEOUT(64)) u_dut8 (
    .clk_i          (clk),
    .rst_i          (rst),
    .sample_valid_i (b_sample_valid),
    .sample_i       (b_sample),
    .sample_ready_o (b_ready),
    .sqrt_start_o   (b_start),
    .sqrt_a_o       (b_a),
    .sqrt_valid_i   (b_sqrt_valid),
    .sqrt_result_i  (b_sqrt_result),
    .rms_valid_o    (b_rms_valid),
    .rms_o          (b_rms),
    .busy_o         (b_busy),
    .err_o          (b_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] isqrt(input logic [63:0] a);
    logic [63:0] r = 64'd0;
    logic [63:0] t;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= a) r = t;
    end
    return r;
  endfunction

  // Square-root unit model: answers sq_lat cycles after the start cycle (0 = never).
  initial begin
    sqrt_valid_i  = 1'b0;
    sqrt_result_i = '0;
    forever begin
      @(negedge clk);
      if (sqrt_start_o && sq_lat > 0) begin
        m_a = 64'(sqrt_a_o);
        repeat (sq_lat) @(posedge clk);
        #1;
        sqrt_valid_i  = 1'b1;
        sqrt_result_i = 16'(isqrt(m_a));
        @(posedge clk);
        #1;
        sqrt_valid_i  = 1'b0;
      end
    end
  end

  // Output monitor: pops expectations as start / rms pulses appear.
  initial begin
    forever begin
      @(negedge clk);
      if (sqrt_start_o) begin
        n_start++;
        s_cyc = cyc;
        if (q_a.size() != 0) chk("sqrt_a", 64'(sqrt_a_o), q_a.pop_front());
        else chk("unexpected_start", 64'(sqrt_start_o), 64'd0);
      end
      if (rms_valid_o) begin
        n_rms++;
        if (q_rms.size() != 0) chk("rms_o", 64'(rms_o), q_rms.pop_front());
        else chk("unexpected_rms_valid", 64'(rms_valid_o), 64'd0);
      end
    end
  end

  task automatic send(input logic [15:0] v);
    int n = 0;
    @(posedge clk);
    #1;
    while (!sample_ready_o && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready_wait", 64'(sample_ready_o), 64'd1);
    sample_valid_i = 1'b1;
    sample_i       = v;
    acc_cyc        = cyc;
    @(posedge clk);
    #1;
    sample_valid_i = 1'b0;
  endtask

  task automatic send8(input logic [15:0] v);
    int n = 0;
    @(posedge clk);
    #1;
    while (!b_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!b_ready) chk("ready8_wait", 64'(b_ready), 64'd1);
    b_sample_valid = 1'b1;
    b_sample       = v;
    @(posedge clk);
    #1;
    b_sample_valid = 1'b0;
  endtask

  task automatic run_window(input int v[4], input bit push_rms, input bit gap_chk);
    longint s = 0;
    int prev = 0;
    foreach (v[j]) s += longint'(v[j]) * longint'(v[j]);
    q_a.push_back(64'(s >> 2));
    if (push_rms) q_rms.push_back(isqrt(64'(s >> 2)));
    for (int j = 0; j < 4; j++) begin
      send(16'(v[j]));
      if (gap_chk && j > 0) chk("ready_gap", 64'(acc_cyc - prev), 64'd18);
      prev = acc_cyc;
    end
  endtask

  task automatic wait_rms(input int nb);
    int k = 0;
    while (n_rms == nb && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("rms_arrived", 64'(n_rms > nb), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb_s, nb_r, k;
    longint s;
    rst = 1'b1;
    sample_valid_i = 1'b0;
    sample_i = '0;
    b_sample_valid = 1'b0;
    b_sample = '0;
    b_sqrt_valid = 1'b0;
    b_sqrt_result = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_err", 64'(err_o), 0);
    chk("rst_rms", 64'(rms_o), 0);
    chk("rst_a", 64'(sqrt_a_o), 0);
    chk("rst_start", 64'(sqrt_start_o), 0);
    chk("rst_rms_valid", 64'(rms_valid_o), 0);
    chk("rst_ready", 64'(sample_ready_o), 1);

    // small window: 3, 4, -5, 0 -> mean square 12, rms 3
    nb_s = n_start; nb_r = n_rms;
    run_window('{3, 4, -5, 0}, 1'b1, 1'b1);
    wait_rms(nb_r);
    chk("t1_starts", 64'(n_start - nb_s), 1);
    chk("t1_rms_pulses", 64'(n_rms - nb_r), 1);
    chk("t1_rms_hold", 64'(rms_o), 3);
    chk("t1_err", 64'(err_o), 0);

    // sqrt unit silent -> timeout
    sq_lat = 0;
    nb_r = n_rms;
    run_window('{10, 10, 10, 10}, 1'b0, 1'b0);
    k = 0;
    while (!err_o && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("t4_err_set", 64'(err_o), 1);
    chk("t4_err_latency", 64'(cyc - s_cyc), 65);
    chk("t4_rms_kept", 64'(rms_o), 3);
    chk("t4_busy", 64'(busy_o), 0);
    chk("t4_ready", 64'(sample_ready_o), 1);
    chk("t4_no_rms", 64'(n_rms - nb_r), 0);

    // result arriving on the timeout cycle wins; first sample clears err
    sq_lat = 64;
    nb_r = n_rms;
    q_a.push_back(64'd49);
    q_rms.push_back(64'd7);
    send(16'd7);
    @(negedge clk);
    chk("t4_err_clear", 64'(err_o), 0);
    send(16'd7);
    send(16'd7);
    send(16'd7);
    wait_rms(nb_r);
    chk("t6_err", 64'(err_o), 0);
    chk("t6_rms", 64'(rms_o), 7);

    // valid held high: only every 18th cycle's sample is taken
    sq_lat = 20;
    nb_r = n_rms;
    s = 0;
    for (int i = 0; i < 55; i += 18) s += longint'(i * 37 - 1000) * longint'(i * 37 - 1000);
    q_a.push_back(64'(s >> 2));
    q_rms.push_back(isqrt(64'(s >> 2)));
    @(posedge clk);
    #1;
    for (int i = 0; i < 55; i++) begin
      sample_valid_i = 1'b1;
      sample_i = 16'(i * 37 - 1000);
      @(posedge clk);
      #1;
    end
    sample_valid_i = 1'b0;
    wait_rms(nb_r);
    chk("t3_rms_pulses", 64'(n_rms - nb_r), 1);

    // reset on cycle 7 of SQUARE discards the partial window
    send(16'd100);
    send(16'd200);
    send(16'd300);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_busy", 64'(busy_o), 0);
    chk("t5_err", 64'(err_o), 0);
    chk("t5_rms", 64'(rms_o), 0);
    chk("t5_a", 64'(sqrt_a_o), 0);
    chk("t5_start", 64'(sqrt_start_o), 0);
    chk("t5_rms_valid", 64'(rms_valid_o), 0);
    nb_r = n_rms;
    run_window('{2, 2, 2, 2}, 1'b1, 1'b0);
    wait_rms(nb_r);
    chk("t5_rms_hold", 64'(rms_o), 2);

    // full-scale 256-sample window on the LOG2_N=8 instance
    for (int i = 0; i < 256; i++) send8(16'h8000);
    k = 0;
    while (!b_start && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t2_start", 64'(b_start), 1);
    chk("t2_sqrt_a", 64'(b_a), 64'h0040000000);
    repeat (3) @(posedge clk);
    #1;
    b_sqrt_valid = 1'b1;
    b_sqrt_result = 16'(isqrt(64'h0040000000));
    @(posedge clk);
    #1 b_sqrt_valid = 1'b0;
    k = 0;
    while (!b_rms_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t2_rms_valid", 64'(b_rms_valid), 1);
    chk("t2_rms", 64'(b_rms), 64'h8000);
    chk("t2_err", 64'(b_err), 0);

    repeat (5) @(negedge clk);
    chk("q_a_left", 64'(q_a.size()), 0);
    chk("q_rms_left", 64'(q_rms.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
